lii_req_arbiter: RTL and testbench
==================================

Name: lii_req_arbiter

Overview:
- Shares one LII request stream (toward the LII fabric) among NUM_PORTS memory-wrapper request streams.
- Arbitration is round-robin at packet granularity: a grant is held from header flit to tlast.
- The output is registered through a 2-entry skid buffer.
- The block also demultiplexes the shared LII response stream back to the requesters by the resp dst field, and counts undeliverable responses.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- LII_DW, 64, LII flit data width; keep/strb are LII_DW/8.
- PORT_ID_BASE, 8'h10, LII node ID of port 0; port i has ID PORT_ID_BASE+i.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_req_tdata  in  NUM_PORTS*LII_DW  per-port request data, port i at [i*LII_DW +: LII_DW].
- s_req_tkeep  in  NUM_PORTS*LII_DW/8  per-port keep.
- s_req_tstrb  in  NUM_PORTS*LII_DW/8  per-port strb.
- s_req_tlast  in  NUM_PORTS  per-port last.
- s_req_src  in  NUM_PORTS*8  per-port src ID.
- s_req_dst  in  NUM_PORTS*8  per-port dst ID.
- s_req_tvalid  in  NUM_PORTS  per-port valid.
- s_req_tready  out  NUM_PORTS  per-port ready.
- m_req_tdata/tkeep/tstrb/tlast/src/dst/tvalid  out  LII_DW, LII_DW/8, LII_DW/8, 1, 8, 8, 1  shared request stream.
- m_req_tready  in  1  fabric ready.
- s_resp_tdata/tkeep/tstrb/tlast/src/dst/tvalid  in  LII_DW, LII_DW/8, LII_DW/8, 1, 8, 8, 1  shared response stream.
- s_resp_tready  out  1.
- m_resp_tdata/tkeep/tstrb  out  NUM_PORTS*(LII_DW, LII_DW/8, LII_DW/8)  per-port response, broadcast data.
- m_resp_tlast/src/dst  out  NUM_PORTS, NUM_PORTS*8, NUM_PORTS*8  broadcast.
- m_resp_tvalid  out  NUM_PORTS  one-hot or zero.
- m_resp_tready  in  NUM_PORTS.
- grant_idx  out  $clog2(NUM_PORTS)  current/last granted port, for debug.
- busy  out  1  high in ST_PASS.
- drop_cnt  out  16  responses dropped for unmatched dst; saturating.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=ST_ARB, rr_ptr=0, grant_idx=0.
  - Skid buffer empty; m_req_tvalid=0; all s_req_tready=0; drop_cnt=0.
  - Reset mid-packet discards buffered flits; no partial-packet recovery.
- FSM ST_ARB:
  - All s_req_tready=0.
  - If any s_req_tvalid: pick the first valid index scanning rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - Register it in grant_idx; next state ST_PASS.
  - One bubble cycle per packet is intended.
- FSM ST_PASS:
  - s_req_tready[grant_idx] = skid_can_accept; all other ports 0.
  - A handshake pushes the flit (data, keep, strb, last, src, dst) into the skid buffer unchanged.
  - On a handshake with tlast=1: rr_ptr <= grant_idx+1 (wraps to 0 at NUM_PORTS), next state ST_ARB.
  - A valid drop by the granted port mid-packet simply stalls; the grant is not released.
- Skid buffer:
  - 2 entries; m_req_* driven from the head register only, so no combinational path from s_req to m_req.
  - skid_can_accept = count<2, or count==2 with m_req_tready and pop this cycle not allowed. The ready is registered as count<2 to break the timing path.
  - Latency: flit accepted at cycle t is visible on m_req at t+1.
  - Simultaneous push and pop keeps count unchanged; order is preserved.
  - Full-rate throughput with m_req_tready held high.
- Response demux (combinational, no state except drop_cnt):
  - idx = s_resp_dst - PORT_ID_BASE.
  - If idx < NUM_PORTS: m_resp_tvalid[idx] = s_resp_tvalid and s_resp_tready = m_resp_tready[idx].
  - Otherwise: s_resp_tready=1 (sink), and drop_cnt increments on each valid beat, saturating at 16'hFFFF.
  - Arithmetic is 8-bit unsigned; dst < PORT_ID_BASE wraps to a large value and is treated as unmatched.
- busy=1 exactly in ST_PASS.

Decomposition:
- Package lii_pkg:
  - OP_READ=2'b00, OP_WRITE=2'b01, RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Header field widths, LII_SRCDST_W=8.
  - Typedef lii_flit_t, a packed struct of data, keep, strb, last, src, dst sized by LII_DW.
- Sub-module lii_skid_buf:
  - 2-entry register buffer, parameterised on flit width.
  - Reused by other LII endpoints.

Test Plan:
- Single port 0 sends a 1-flit READ header with tdata=64'hABCD, dst=8'h01 -> m_req_tvalid rises 2 cycles after s_req_tvalid (ARB, PASS, then output); data, src and dst match; rr_ptr=1.
- Ports 1 and 3 both hold 3-flit write packets (header + 2 data, tlast on flit 3) -> port 1's 3 flits are contiguous, then port 3's 3 flits; no interleave; grant_idx sequence 1 then 3.
- All 4 ports continuously valid with 1-flit packets for 8 packets -> grant order 0,1,2,3,0,1,2,3.
- m_req_tready low 5 cycles during port 2's 4-flit packet -> skid fills to 2, s_req_tready[2]=0, no flit lost or duplicated, order preserved after release.
- Response with dst=8'h12 then dst=8'h30 (PORT_ID_BASE=8'h10) -> first beat on m_resp_tvalid[2] honouring m_resp_tready[2]; second sunk with drop_cnt=1.
- Assert rst during port 0's 2nd of 4 flits -> immediately m_req_tvalid=0, busy=0, drop_cnt=0; after release, port 1's packet is granted first if port 0 is not valid.

Source files
------------

// File: rtl/lii_pkg.sv
// rtl/lii_pkg.sv - shared LII opcodes, field widths and flit layout
package lii_pkg;
    localparam int LII_DW_DEF   = 64;
    localparam int LII_KW_DEF   = LII_DW_DEF / 8;
    localparam int LII_SRCDST_W = 8;
    localparam int LII_OP_W     = 2;
    localparam int LII_RESP_W   = 2;

    localparam logic [LII_OP_W-1:0]   OP_READ     = 2'b00;
    localparam logic [LII_OP_W-1:0]   OP_WRITE    = 2'b01;
    localparam logic [LII_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [LII_RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [LII_DW_DEF-1:0]   data;
        logic [LII_KW_DEF-1:0]   keep;
        logic [LII_KW_DEF-1:0]   strb;
        logic                    last;
        logic [LII_SRCDST_W-1:0] src;
        logic [LII_SRCDST_W-1:0] dst;
    } lii_flit_t;

    localparam int LII_FLIT_W = $bits(lii_flit_t);
endpackage

// File: rtl/lii_skid_buf.sv
// rtl/lii_skid_buf.sv - 2-entry registered skid buffer, output driven from head register only
module lii_skid_buf #(
    parameter int W = 89
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    // Ready depends only on the count register, breaking the path from the downstream ready.
    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (w_pop && r_count == 2'd2) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
        end else if (w_push && w_pop) begin
            r_head  <= i_data;
        end else if (w_push) begin
            if (r_count == 2'd0) r_head <= i_data;
            else                 r_tail <= i_data;
            r_count <= r_count + 2'd1;
        end else if (w_pop) begin
            r_count <= r_count - 2'd1;
        end
    end
endmodule

// File: rtl/lii_req_arbiter.sv
// rtl/lii_req_arbiter.sv - packet-granular round-robin LII request arbiter with response demux
module lii_req_arbiter
    import lii_pkg::*;
#(
    parameter int          NUM_PORTS    = 4,
    parameter int          LII_DW       = 64,
    parameter logic [7:0]  PORT_ID_BASE = 8'h10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS*LII_DW-1:0]       s_req_tdata,
    input  logic [NUM_PORTS*LII_DW/8-1:0]     s_req_tkeep,
    input  logic [NUM_PORTS*LII_DW/8-1:0]     s_req_tstrb,
    input  logic [NUM_PORTS-1:0]              s_req_tlast,
    input  logic [NUM_PORTS*8-1:0]            s_req_src,
    input  logic [NUM_PORTS*8-1:0]            s_req_dst,
    input  logic [NUM_PORTS-1:0]              s_req_tvalid,
    output logic [NUM_PORTS-1:0]              s_req_tready,
    output logic [LII_DW-1:0]                 m_req_tdata,
    output logic [LII_DW/8-1:0]               m_req_tkeep,
    output logic [LII_DW/8-1:0]               m_req_tstrb,
    output logic                              m_req_tlast,
    output logic [7:0]                        m_req_src,
    output logic [7:0]                        m_req_dst,
    output logic                              m_req_tvalid,
    input  logic                              m_req_tready,
    input  logic [LII_DW-1:0]                 s_resp_tdata,
    input  logic [LII_DW/8-1:0]               s_resp_tkeep,
    input  logic [LII_DW/8-1:0]               s_resp_tstrb,
    input  logic                              s_resp_tlast,
    input  logic [7:0]                        s_resp_src,
    input  logic [7:0]                        s_resp_dst,
    input  logic                              s_resp_tvalid,
    output logic                              s_resp_tready,
    output logic [NUM_PORTS*LII_DW-1:0]       m_resp_tdata,
    output logic [NUM_PORTS*LII_DW/8-1:0]     m_resp_tkeep,
    output logic [NUM_PORTS*LII_DW/8-1:0]     m_resp_tstrb,
    output logic [NUM_PORTS-1:0]              m_resp_tlast,
    output logic [NUM_PORTS*8-1:0]            m_resp_src,
    output logic [NUM_PORTS*8-1:0]            m_resp_dst,
    output logic [NUM_PORTS-1:0]              m_resp_tvalid,
    input  logic [NUM_PORTS-1:0]              m_resp_tready,
    output logic [$clog2(NUM_PORTS)-1:0]      grant_idx,
    output logic                              busy,
    output logic [15:0]                       drop_cnt
);
    localparam int KW = LII_DW / 8;
    localparam int IW = $clog2(NUM_PORTS);
    localparam int FW = LII_DW + 2*KW + 1 + 2*LII_SRCDST_W;

    typedef enum logic {ST_ARB, ST_PASS} state_t;

    state_t        r_state;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_grant;
    logic [15:0]   r_drop;
    logic [IW-1:0] w_pick;
    logic          w_any;
    logic [IW:0]   w_scan;
    logic          w_can_accept;
    logic          w_in_valid;
    logic          w_hs;
    logic [FW-1:0] w_in_flit;
    logic [FW-1:0] w_out_flit;
    logic [7:0]    w_resp_idx;
    logic          w_resp_hit;

    // Scan from the farthest offset down so the port closest to rr_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_rr_ptr;
        w_scan = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_scan >= (IW+1)'(NUM_PORTS)) w_scan = w_scan - (IW+1)'(NUM_PORTS);
            if (s_req_tvalid[w_scan[IW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_scan[IW-1:0];
            end
        end
    end

    assign w_in_valid = (r_state == ST_PASS) && s_req_tvalid[r_grant];
    assign w_hs       = w_in_valid && w_can_accept;
    assign w_in_flit  = {s_req_tdata[r_grant*LII_DW +: LII_DW], s_req_tkeep[r_grant*KW +: KW],
                         s_req_tstrb[r_grant*KW +: KW], s_req_tlast[r_grant],
                         s_req_src[r_grant*8 +: 8], s_req_dst[r_grant*8 +: 8]};

    always_comb begin
        s_req_tready = '0;
        if (r_state == ST_PASS) s_req_tready[r_grant] = w_can_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_ARB;
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            case (r_state)
                ST_ARB: if (w_any) begin
                    r_grant <= w_pick;
                    r_state <= ST_PASS;
                end
                ST_PASS: if (w_hs && s_req_tlast[r_grant]) begin
                    r_rr_ptr <= (r_grant == IW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
                    r_state  <= ST_ARB;
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    lii_skid_buf #(.W(FW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_in_flit),
        .i_valid (w_in_valid),
        .o_ready (w_can_accept),
        .o_data  (w_out_flit),
        .o_valid (m_req_tvalid),
        .i_ready (m_req_tready)
    );

    assign {m_req_tdata, m_req_tkeep, m_req_tstrb, m_req_tlast, m_req_src, m_req_dst} = w_out_flit;
    assign grant_idx = r_grant;
    assign busy      = (r_state == ST_PASS);

    // Destinations below the base wrap to large indices and fall into the sink path.
    assign w_resp_idx = s_resp_dst - PORT_ID_BASE;
    assign w_resp_hit = (w_resp_idx < 8'(NUM_PORTS));

    always_comb begin
        m_resp_tvalid = '0;
        s_resp_tready = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_resp_idx == 8'(i)) begin
                m_resp_tvalid[i] = s_resp_tvalid;
                s_resp_tready    = m_resp_tready[i];
            end
        end
    end

    assign m_resp_tdata = {NUM_PORTS{s_resp_tdata}};
    assign m_resp_tkeep = {NUM_PORTS{s_resp_tkeep}};
    assign m_resp_tstrb = {NUM_PORTS{s_resp_tstrb}};
    assign m_resp_tlast = {NUM_PORTS{s_resp_tlast}};
    assign m_resp_src   = {NUM_PORTS{s_resp_src}};
    assign m_resp_dst   = {NUM_PORTS{s_resp_dst}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                      r_drop <= 16'd0;
        else if (s_resp_tvalid && !w_resp_hit && r_drop != 16'hFFFF)  r_drop <= r_drop + 16'd1;
    end

    assign drop_cnt = r_drop;
endmodule

// File: tb/tb_lii_req_arbiter.sv
// tb/tb_lii_req_arbiter.sv - directed self-checking bench for lii_req_arbiter
module tb_lii_req_arbiter;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    logic              clk;
    logic              rst;
    logic [NP*DW-1:0]  s_req_tdata;
    logic [NP*KW-1:0]  s_req_tkeep;
    logic [NP*KW-1:0]  s_req_tstrb;
    logic [NP-1:0]     s_req_tlast;
    logic [NP*8-1:0]   s_req_src;
    logic [NP*8-1:0]   s_req_dst;
    logic [NP-1:0]     s_req_tvalid;
    logic [NP-1:0]     s_req_tready;
    logic [DW-1:0]     m_req_tdata;
    logic [KW-1:0]     m_req_tkeep;
    logic [KW-1:0]     m_req_tstrb;
    logic              m_req_tlast;
    logic [7:0]        m_req_src;
    logic [7:0]        m_req_dst;
    logic              m_req_tvalid;
    logic              m_req_tready;
    logic [DW-1:0]     s_resp_tdata;
    logic [KW-1:0]     s_resp_tkeep;
    logic [KW-1:0]     s_resp_tstrb;
    logic              s_resp_tlast;
    logic [7:0]        s_resp_src;
    logic [7:0]        s_resp_dst;
    logic              s_resp_tvalid;
    logic              s_resp_tready;
    logic [NP*DW-1:0]  m_resp_tdata;
    logic [NP*KW-1:0]  m_resp_tkeep;
    logic [NP*KW-1:0]  m_resp_tstrb;
    logic [NP-1:0]     m_resp_tlast;
    logic [NP*8-1:0]   m_resp_src;
    logic [NP*8-1:0]   m_resp_dst;
    logic [NP-1:0]     m_resp_tvalid;
    logic [NP-1:0]     m_resp_tready;
    logic [1:0]        grant_idx;
    logic              busy;
    logic [15:0]       drop_cnt;

    lii_req_arbiter #(.NUM_PORTS(NP), .LII_DW(DW), .PORT_ID_BASE(8'h10)) dut (
        .clk(clk), .rst(rst),
        .s_req_tdata(s_req_tdata), .s_req_tkeep(s_req_tkeep), .s_req_tstrb(s_req_tstrb),
        .s_req_tlast(s_req_tlast), .s_req_src(s_req_src), .s_req_dst(s_req_dst),
        .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
        .m_req_tdata(m_req_tdata), .m_req_tkeep(m_req_tkeep), .m_req_tstrb(m_req_tstrb),
        .m_req_tlast(m_req_tlast), .m_req_src(m_req_src), .m_req_dst(m_req_dst),
        .m_req_tvalid(m_req_tvalid), .m_req_tready(m_req_tready),
        .s_resp_tdata(s_resp_tdata), .s_resp_tkeep(s_resp_tkeep), .s_resp_tstrb(s_resp_tstrb),
        .s_resp_tlast(s_resp_tlast), .s_resp_src(s_resp_src), .s_resp_dst(s_resp_dst),
        .s_resp_tvalid(s_resp_tvalid), .s_resp_tready(s_resp_tready),
        .m_resp_tdata(m_resp_tdata), .m_resp_tkeep(m_resp_tkeep), .m_resp_tstrb(m_resp_tstrb),
        .m_resp_tlast(m_resp_tlast), .m_resp_src(m_resp_src), .m_resp_dst(m_resp_dst),
        .m_resp_tvalid(m_resp_tvalid), .m_resp_tready(m_resp_tready),
        .grant_idx(grant_idx), .busy(busy), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  dst;
        logic        vld;
        logic [3:0]  rdy;
        logic [3:0]  exp_mv;
        logic        exp_sr;
        logic [15:0] exp_drop;
    } rvec_t;

    rvec_t       rv [9];
    int          total = 0;
    int          bad   = 0;
    logic [64:0] pq [NP][$];
    logic [72:0] exp_q [$];
    int          gq [$];
    int          stall_seen;
    logic        prev_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int p, input int k, input int f);
        return {40'hA5A5A5A5A5, 8'(p), 8'(k), 8'(f)};
    endfunction

    task automatic add_pkt(input int p, input int k, input int n);
        logic [63:0] d;
        logic        l;
        for (int f = 0; f < n; f++) begin
            d = mk(p, k, f);
            l = (f == n - 1);
            pq[p].push_back({l, d});
            exp_q.push_back({8'h10 + 8'(p), l, d});
        end
    endtask

    task automatic drive_ports();
        logic [64:0] h;
        for (int p = 0; p < NP; p++) begin
            if (pq[p].size() > 0) begin
                h = pq[p][0];
                s_req_tvalid[p]          = 1'b1;
                s_req_tdata[p*DW +: DW]  = h[63:0];
                s_req_tlast[p]           = h[64];
            end else begin
                s_req_tvalid[p] = 1'b0;
            end
        end
    endtask

    task automatic run_cycles(input int n, input int lo_s, input int lo_e);
        logic [NP-1:0] hs;
        logic [72:0]   e;
        for (int c = 0; c < n; c++) begin
            m_req_tready = !(c >= lo_s && c <= lo_e);
            drive_ports();
            @(negedge clk);
            hs = s_req_tvalid & s_req_tready;
            chk("rdy_onehot", 64'($countones(s_req_tready) <= 1), 64'd1);
            if (busy && !prev_busy) gq.push_back(int'(grant_idx));
            prev_busy = busy;
            if (c >= lo_s && c <= lo_e && busy && !s_req_tready[2]) stall_seen++;
            if (m_req_tvalid && m_req_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_flit: got %h want none", m_req_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("flit_data", m_req_tdata, e[63:0]);
                    chk("flit_last", 64'(m_req_tlast), 64'(e[64]));
                    chk("flit_src", 64'(m_req_src), 64'(e[72:65]));
                end
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) if (hs[p]) void'(pq[p].pop_front());
            drive_ports();
        end
        m_req_tready = 1'b1;
        chk("all_flits_seen", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int g3 [8];
        g3 = '{0, 1, 2, 3, 0, 1, 2, 3};
        rv[0] = '{8'h12, 1'b1, 4'b0000, 4'b0100, 1'b0, 16'd0};
        rv[1] = '{8'h12, 1'b1, 4'b0100, 4'b0100, 1'b1, 16'd0};
        rv[2] = '{8'h30, 1'b1, 4'b0000, 4'b0000, 1'b1, 16'd1};
        rv[3] = '{8'h05, 1'b1, 4'b1111, 4'b0000, 1'b1, 16'd2};
        rv[4] = '{8'h13, 1'b1, 4'b1000, 4'b1000, 1'b1, 16'd2};
        rv[5] = '{8'h10, 1'b1, 4'b0001, 4'b0001, 1'b1, 16'd2};
        rv[6] = '{8'h30, 1'b0, 4'b0000, 4'b0000, 1'b1, 16'd2};
        rv[7] = '{8'h14, 1'b1, 4'b1111, 4'b0000, 1'b1, 16'd3};
        rv[8] = '{8'h0F, 1'b1, 4'b0000, 4'b0000, 1'b1, 16'd4};

        rst = 1'b1;
        s_req_tdata = '0; s_req_tkeep = '1; s_req_tstrb = {NP{8'h0F}}; s_req_tlast = '0;
        s_req_src = {8'h13, 8'h12, 8'h11, 8'h10}; s_req_dst = {NP{8'h01}};
        s_req_tvalid = '0; m_req_tready = 1'b1;
        s_resp_tdata = '0; s_resp_tkeep = '1; s_resp_tstrb = '1; s_resp_tlast = 1'b1;
        s_resp_src = 8'h01; s_resp_dst = 8'h00; s_resp_tvalid = 1'b0; m_resp_tready = '0;
        stall_seen = 0; prev_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_m_valid", 64'(m_req_tvalid), 64'd0);
        chk("rst_s_ready", 64'(s_req_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);

        // Single 1-flit READ header from port 0
        s_req_tdata[63:0] = 64'hABCD; s_req_tlast[0] = 1'b1; s_req_tvalid[0] = 1'b1;
        #1 chk("s1_arb_ready", 64'(s_req_tready), 64'd0);
        @(posedge clk); #1;
        chk("s1_busy", 64'(busy), 64'd1);
        chk("s1_grant", 64'(grant_idx), 64'd0);
        chk("s1_ready", 64'(s_req_tready), 64'b0001);
        chk("s1_m_valid_early", 64'(m_req_tvalid), 64'd0);
        @(posedge clk); #1;
        s_req_tvalid[0] = 1'b0;
        chk("s1_m_valid", 64'(m_req_tvalid), 64'd1);
        chk("s1_data", m_req_tdata, 64'hABCD);
        chk("s1_src", 64'(m_req_src), 64'h10);
        chk("s1_dst", 64'(m_req_dst), 64'h01);
        chk("s1_strb", 64'(m_req_tstrb), 64'h0F);
        chk("s1_last", 64'(m_req_tlast), 64'd1);
        chk("s1_busy_off", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("s1_m_valid_off", 64'(m_req_tvalid), 64'd0);

        // Ports 1 and 3 with 3-flit packets; rr_ptr=1 so port 1 goes first
        add_pkt(1, 0, 3);
        add_pkt(3, 0, 3);
        run_cycles(20, 100, 100);
        chk("s2_grant_cnt", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            chk("s2_grant0", 64'(gq[0]), 64'd1);
            chk("s2_grant1", 64'(gq[1]), 64'd3);
        end
        gq.delete();

        // All ports continuously valid, 1-flit packets
        for (int k = 0; k < 2; k++) for (int p = 0; p < NP; p++) add_pkt(p, k, 1);
        run_cycles(30, 100, 100);
        chk("s3_grant_cnt", 64'(gq.size()), 64'd8);
        for (int i = 0; i < 8; i++) if (i < gq.size()) chk("s3_grant_seq", 64'(gq[i]), 64'(g3[i]));
        gq.delete();

        // Port 2 4-flit packet with m_req_tready low for 5 cycles
        add_pkt(2, 0, 4);
        stall_seen = 0;
        run_cycles(20, 2, 6);
        chk("s4_stalled", 64'(stall_seen > 0), 64'd1);
        chk("s4_grant", 64'(gq.size() == 1 && gq[0] == 2), 64'd1);
        gq.delete();

        // Response demux table
        for (int r = 0; r < 9; r++) begin
            s_resp_dst    = rv[r].dst;
            s_resp_tvalid = rv[r].vld;
            m_resp_tready = rv[r].rdy;
            s_resp_tdata  = 64'h5000 + 64'(r);
            #1;
            chk("resp_mvalid", 64'(m_resp_tvalid), 64'(rv[r].exp_mv));
            chk("resp_sready", 64'(s_resp_tready), 64'(rv[r].exp_sr));
            chk("resp_bcast", m_resp_tdata[(r % NP)*DW +: DW], 64'h5000 + 64'(r));
            @(posedge clk); #1;
            chk("resp_drop", 64'(drop_cnt), 64'(rv[r].exp_drop));
        end
        s_resp_tvalid = 1'b0;

        // Reset during port 0's second flit
        s_req_tdata[63:0] = mk(0, 5, 0); s_req_tlast[0] = 1'b0; s_req_tvalid = 4'b0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_req_tdata[63:0] = mk(0, 5, 1);
        chk("s6_pre_valid", 64'(m_req_tvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("s6_rst_valid", 64'(m_req_tvalid), 64'd0);
        chk("s6_rst_busy", 64'(busy), 64'd0);
        chk("s6_rst_drop", 64'(drop_cnt), 64'd0);
        chk("s6_rst_ready", 64'(s_req_tready), 64'd0);
        s_req_tvalid = 4'b1010;
        s_req_tdata[1*DW +: DW] = mk(1, 9, 0); s_req_tlast[1] = 1'b1;
        s_req_tdata[3*DW +: DW] = mk(3, 9, 0); s_req_tlast[3] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("s6_held_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("s6_busy", 64'(busy), 64'd1);
        chk("s6_grant", 64'(grant_idx), 64'd1);
        chk("s6_ready", 64'(s_req_tready), 64'b0010);
        @(posedge clk); #1;
        s_req_tvalid = 4'b0000;
        chk("s6_m_valid", 64'(m_req_tvalid), 64'd1);
        chk("s6_data", m_req_tdata, mk(1, 9, 0));
        chk("s6_src", 64'(m_req_src), 64'h11);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
